// File: rtl/scan_integrity_checker_if.sv
// rtl/scan_integrity_checker_if.sv - control/result bundle for the scan integrity checker
//
// Purpose: groups the checker's control strobes, serial data input and result
//          outputs so that the driver (master) and the checker (slave) share a
//          single connection.
// Ports (seen from the slave side):
//   en          in   block enable; low freezes all state
//   capture_en  in   start a new frame
//   shift_en    in   sample sdi this cycle
//   update_en   in   clear err_cnt (IDLE/DONE only)
//   sdi         in   decrypted serial data, payload then tag, MSB first
//   sig         out  CRC of the last completed payload
//   busy        out  frame in progress (DATA, TAG, CHECK)
//   done        out  result valid
//   pass/fail   out  tag compare outcome
//   err_cnt     out  saturating count of failed frames
interface scan_integrity_checker_if;
  logic        en;
  logic        capture_en;
  logic        shift_en;
  logic        update_en;
  logic        sdi;
  logic [31:0] sig;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic [7:0]  err_cnt;

  modport master (
    output en, capture_en, shift_en, update_en, sdi,
    input  sig, busy, done, pass, fail, err_cnt
  );

  modport slave (
    input  en, capture_en, shift_en, update_en, sdi,
    output sig, busy, done, pass, fail, err_cnt
  );
endinterface

// File: rtl/scan_integrity_checker.sv
// rtl/scan_integrity_checker.sv - CRC-32 integrity check of decrypted scan-out frames
//
// Purpose: computes an MSB-first CRC over each FRAME_LEN-bit payload arriving
//          on bus.sdi, captures the TAG_W-bit tag that follows it, compares the
//          two and reports pass/fail plus a saturating failed-frame count.
// Ports:
//   tck      in   test clock, all state updates on the rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of scan_integrity_checker_if (controls, sdi, results)
module scan_integrity_checker #(
  parameter int          FRAME_LEN = 128,
  parameter int          TAG_W     = 32,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] SEED      = 32'hFFFFFFFF
) (
  input  logic                      tck,
  input  logic                      reset_n,
  scan_integrity_checker_if.slave   bus
);

  localparam int CW = $clog2(FRAME_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_TAG   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The TAG phase reuses the payload counter, so it must be wide enough for both.
  localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_TAG  = CW'(TAG_W - 1);

  logic [2:0]    state;
  logic [31:0]   crc;
  logic [31:0]   tag;
  logic [CW-1:0] cnt;
  logic [31:0]   sig_q;
  logic          pass_q;
  logic          fail_q;
  logic [7:0]    err_cnt_q;

  logic          fb;
  assign fb = crc[31] ^ bus.sdi;

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      crc       <= SEED;
      tag       <= '0;
      cnt       <= '0;
      sig_q     <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
    end else if (bus.en) begin
      if (bus.capture_en) begin
        // Restart from any state; a partially received frame is simply dropped.
        state  <= S_DATA;
        crc    <= SEED;
        cnt    <= '0;
        tag    <= '0;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end else begin
        case (state)
          S_DATA: begin
            if (bus.shift_en) begin
              crc <= {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
              if (cnt == LAST_DATA) begin
                state <= S_TAG;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          S_TAG: begin
            if (bus.shift_en) begin
              tag <= {tag[30:0], bus.sdi};
              cnt <= cnt + CW'(1);
              if (cnt == LAST_TAG) begin
                state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            sig_q  <= crc;
            pass_q <= (tag == crc);
            fail_q <= (tag != crc);
            if ((tag != crc) && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state <= S_DONE;
          end
          S_IDLE, S_DONE: begin
            if (bus.update_en) begin
              err_cnt_q <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Status flags decode straight from the state register, never from inputs.
  assign bus.busy    = (state == S_DATA) || (state == S_TAG) || (state == S_CHECK);
  assign bus.done    = (state == S_DONE);
  assign bus.sig     = sig_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_scan_integrity_checker.sv
// tb/tb_scan_integrity_checker.sv - directed self-checking bench for scan_integrity_checker
//
// Purpose: drives a SEED=0 instance (dut0) and a default-parameter instance
//          (dut1) with the same stimulus and checks results against hand values
//          and a golden CRC model.
// Ports: none (top-level bench).
module tb_scan_integrity_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic tck = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0, capture_en = 1'b0, shift_en = 1'b0, update_en = 1'b0, sdi = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 tck = ~tck;

  scan_integrity_checker_if b0 ();
  scan_integrity_checker_if b1 ();

  assign b0.en = en;  assign b0.capture_en = capture_en; assign b0.shift_en = shift_en;
  assign b0.update_en = update_en; assign b0.sdi = sdi;
  assign b1.en = en;  assign b1.capture_en = capture_en; assign b1.shift_en = shift_en;
  assign b1.update_en = update_en; assign b1.sdi = sdi;

  scan_integrity_checker #(.SEED(32'h0)) dut0 (.tck(tck), .reset_n(reset_n), .bus(b0));
  scan_integrity_checker dut1 (.tck(tck), .reset_n(reset_n), .bus(b1));

  function automatic logic [31:0] crc_model(input logic [31:0] seed, input logic [127:0] d,
                                            input int n);
    logic [31:0] c;
    logic        f;
    c = seed;
    for (int i = n - 1; i >= 0; i--) begin
      f = c[31] ^ d[i];
      c = {c[30:0], 1'b0} ^ (f ? POLY : 32'h0);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic capture();
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    shift_en = 1'b1;
    sdi = b;
    tick();
    shift_en = 1'b0;
    sdi = 1'b0;
  endtask

  // Shifts the top n bits of a 160-bit {payload, tag} vector, MSB first.
  task automatic send_bits(input logic [159:0] v, input int first, input int n, input bit gaps);
    for (int i = first; i > first - n; i--) begin
      shift_bit(v[i]);
      if (gaps && (i % 7 == 3)) repeat ((i % 5) + 1) tick();
    end
  endtask

  // Full frame after capture, followed by the CHECK edge.
  task automatic send_frame(input logic [127:0] p, input logic [31:0] t, input bit gaps);
    capture();
    send_bits({p, t}, 159, 160, gaps);
    tick();
  endtask

  logic [127:0] pat_a, pat_b, pat_c;
  logic [31:0]  crc_a, crc_b, crc_c;
  logic [127:0] chk_str;

  initial begin
    pat_a   = {16{8'hAA}};
    pat_b   = pat_a ^ (128'h1 << 37);
    pat_c   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    chk_str = 128'h313233343536373839;
    crc_a   = crc_model(32'hFFFFFFFF, pat_a, 128);
    crc_b   = crc_model(32'hFFFFFFFF, pat_b, 128);
    crc_c   = crc_model(32'hFFFFFFFF, pat_c, 128);

    // Golden model against the published CRC-32/MPEG-2 check value of "123456789".
    chk("model_check_string", crc_model(32'hFFFFFFFF, chk_str, 72), 32'h0376E6E7);

    repeat (3) tick();
    reset_n = 1'b1;
    en      = 1'b1;
    tick();
    chk("reset_busy", {31'h0, b0.busy}, 32'h0);
    chk("reset_done", {31'h0, b0.done}, 32'h0);
    chk("reset_pass_fail", {30'h0, b0.pass, b0.fail}, 32'h0);
    chk("reset_sig", b0.sig, 32'h0);
    chk("reset_err_cnt", {24'h0, b0.err_cnt}, 32'h0);

    // Zero payload, zero tag on the SEED=0 instance: edge-exact done timing.
    capture();
    chk("capture_busy", {31'h0, b0.busy}, 32'h1);
    send_bits(160'h0, 159, 160, 1'b0);
    chk("pre_check_done", {30'h0, b0.busy, b0.done}, 32'h2);
    tick();
    chk("zero_done_edge161", {30'h0, b0.busy, b0.done}, 32'h1);
    chk("zero_sig", b0.sig, 32'h0);
    chk("zero_pass_fail", {30'h0, b0.pass, b0.fail}, 32'h2);
    chk("zero_err_cnt", {24'h0, b0.err_cnt}, 32'h0);

    // Mismatching tag, then saturation over 300 failing frames.
    send_frame(128'h0, 32'h1, 1'b0);
    chk("bad_tag_pass_fail", {30'h0, b0.pass, b0.fail}, 32'h1);
    chk("bad_tag_err_cnt", {24'h0, b0.err_cnt}, 32'h1);
    repeat (254) send_frame(128'h0, 32'h1, 1'b0);
    chk("err_cnt_reach_255", {24'h0, b0.err_cnt}, 32'hFF);
    repeat (45) send_frame(128'h0, 32'h1, 1'b0);
    chk("err_cnt_sat_hold", {24'h0, b0.err_cnt}, 32'hFF);

    // update_en in DONE clears both counters.
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
    chk("update_done_dut0", {24'h0, b0.err_cnt}, 32'h0);
    chk("update_done_dut1", {24'h0, b1.err_cnt}, 32'h0);

    // Default parameters: alternating payload with model tag, then a flipped bit.
    send_frame(pat_a, crc_a, 1'b0);
    chk("aa_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h2);
    chk("aa_sig", b1.sig, crc_a);
    chk("aa_err_cnt", {24'h0, b1.err_cnt}, 32'h0);
    send_frame(pat_b, crc_a, 1'b0);
    chk("flip_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h1);
    chk("flip_sig", b1.sig, crc_b);
    chk("flip_err_cnt", {24'h0, b1.err_cnt}, 32'h1);

    // Restart after 70 payload bits, then a clean frame.
    capture();
    send_bits({pat_b, 32'h0}, 159, 70, 1'b0);
    send_frame(pat_c, crc_c, 1'b0);
    chk("restart_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h2);
    chk("restart_sig", b1.sig, crc_c);
    chk("restart_err_cnt", {24'h0, b1.err_cnt}, 32'h1);

    // Same frame with shift_en gaps of 1-5 cycles.
    send_frame(pat_c, crc_c, 1'b1);
    chk("gaps_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h2);
    chk("gaps_sig", b1.sig, crc_c);

    // en low for 20 cycles mid-DATA with active controls: nothing may move.
    capture();
    send_bits({pat_a, crc_a}, 159, 40, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      shift_en   = 1'b1;
      update_en  = 1'b1;
      sdi        = i[0];
      capture_en = (i == 10);
      tick();
    end
    en = 1'b1; shift_en = 1'b0; update_en = 1'b0; capture_en = 1'b0; sdi = 1'b0;
    chk("en_low_busy", {30'h0, b1.busy, b1.done}, 32'h2);
    send_bits({pat_a, crc_a}, 119, 120, 1'b0);
    tick();
    chk("en_low_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h2);
    chk("en_low_sig", b1.sig, crc_a);
    chk("en_low_err_cnt", {24'h0, b1.err_cnt}, 32'h1);

    // update_en in DATA is ignored; then reset mid-TAG without a clock edge.
    capture();
    send_bits({pat_c, crc_c}, 159, 50, 1'b0);
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
    chk("update_in_data_ignored", {24'h0, b1.err_cnt}, 32'h1);
    send_bits({pat_c, crc_c}, 109, 88, 1'b0);
    chk("mid_tag_busy", {30'h0, b1.busy, b1.done}, 32'h2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy_done", {30'h0, b1.busy, b1.done}, 32'h0);
    chk("async_rst_sig", b1.sig, 32'h0);
    chk("async_rst_pass_fail", {30'h0, b1.pass, b1.fail}, 32'h0);
    chk("async_rst_err_cnt", {24'h0, b1.err_cnt}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
